// File: rtl/wishbone_arbiter_n_pkg.sv
// rtl/wishbone_arbiter_n_pkg.sv - shared bus widths, arbitration mode encodings and arbiter state type
package wishbone_arbiter_n_pkg;
  localparam int WB_ADDR_W = 24;
  localparam int WB_DATA_W = 16;
  localparam int WB_SEL_W  = 2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_arb_pick.sv
// rtl/wb_arb_pick.sv - combinational winner selection, fixed priority or round-robin after last owner
module wb_arb_pick
  import wishbone_arbiter_n_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0]         req,
  input  logic [$clog2(NUM_M)-1:0] last,
  input  logic                     mode,
  output logic [$clog2(NUM_M)-1:0] win,
  output logic                     any
);
  localparam int IW = $clog2(NUM_M);

  always_comb begin
    int         idx;
    logic       found;
    logic [IW-1:0] idx_b;
    idx   = 0;
    idx_b = '0;
    found = 1'b0;
    win   = '0;
    // Scan order wraps modulo NUM_M so a non-power-of-two count never yields an index >= NUM_M.
    for (int i = 0; i < NUM_M; i++) begin
      idx   = (mode == 1'(ARB_RR)) ? (int'(last) + 1 + i) % NUM_M : i;
      idx_b = IW'(idx);
      if (!found && req[idx_b]) begin
        win   = idx_b;
        found = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/wishbone_arbiter_n.sv
// rtl/wishbone_arbiter_n.sv - N-master wishbone arbiter with burst-safe grant hold and optional stall watchdog
module wishbone_arbiter_n
  import wishbone_arbiter_n_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int SEL_W   = WB_SEL_W,
  parameter int RR_MODE = ARB_RR,
  parameter int TIMEOUT = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_M-1:0]         i_wb_cyc,
  input  logic [NUM_M-1:0]         i_wb_stb,
  input  logic [NUM_M-1:0]         i_wb_we,
  input  logic [NUM_M*ADDR_W-1:0]  i_wb_adr,
  input  logic [NUM_M*SEL_W-1:0]   i_wb_sel,
  input  logic [NUM_M*DATA_W-1:0]  i_wb_dat,
  input  logic [NUM_M-1:0]         i_wb_4_burst,
  input  logic [NUM_M-1:0]         i_wb_8_burst,
  output logic [NUM_M-1:0]         o_wb_ack,
  output logic [NUM_M-1:0]         o_wb_err,
  output logic [NUM_M-1:0]         o_wb_rty,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDR_W-1:0]        o_wb_adr,
  output logic [SEL_W-1:0]         o_wb_sel,
  output logic [DATA_W-1:0]        o_wb_dat,
  output logic                     o_wb_4_burst,
  output logic                     o_wb_8_burst,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty,
  output logic [$clog2(NUM_M)-1:0] o_grant,
  output logic                     o_grant_valid
);
  localparam int IW = $clog2(NUM_M);

  arb_state_e          state, state_n;
  logic [IW-1:0]       grant, grant_n, last_owner, last_n, pick_last, win;
  logic                any_req, gv, release_c, resp, stall, fire;
  logic [NUM_M-1:0]    owner_oh;
  logic [ADDR_W-1:0]   adr_a [NUM_M];
  logic [SEL_W-1:0]    sel_a [NUM_M];
  logic [DATA_W-1:0]   dat_a [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign adr_a[k] = i_wb_adr[k*ADDR_W +: ADDR_W];
    assign sel_a[k] = i_wb_sel[k*SEL_W +: SEL_W];
    assign dat_a[k] = i_wb_dat[k*DATA_W +: DATA_W];
  end

  assign gv        = (state == ST_OWNED);
  assign resp      = i_wb_ack | i_wb_err | i_wb_rty;
  assign release_c = gv && !i_wb_cyc[grant];
  assign stall     = gv && i_wb_stb[grant] && !resp;
  // On a release edge the outgoing owner becomes the round-robin reference immediately.
  assign pick_last = gv ? grant : last_owner;

  wb_arb_pick #(.NUM_M(NUM_M)) u_pick (
    .req  (i_wb_cyc),
    .last (pick_last),
    .mode (RR_MODE == ARB_RR),
    .win  (win),
    .any  (any_req)
  );

  if (TIMEOUT > 0) begin : g_wdog
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;
    assign fire = stall && (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                            cnt <= '0;
      else if (stall && !fire && !release_c) cnt <= cnt + CW'(1);
      else                                  cnt <= '0;
    end
  end else begin : g_no_wdog
    assign fire = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_owner <= IW'(NUM_M - 1);
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_owner <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_owner;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_OWNED;
          grant_n = win;
        end
      end
      ST_OWNED: begin
        if (!i_wb_cyc[grant]) begin
          last_n = grant;
          if (any_req) grant_n = win;
          else         state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    owner_oh     = '0;
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_adr     = '0;
    o_wb_sel     = '0;
    o_wb_dat     = '0;
    o_wb_4_burst = 1'b0;
    o_wb_8_burst = 1'b0;
    if (gv) begin
      owner_oh[grant] = 1'b1;
      o_wb_cyc        = i_wb_cyc[grant];
      o_wb_stb        = i_wb_stb[grant] && !fire;
      o_wb_we         = i_wb_we[grant];
      o_wb_adr        = adr_a[grant];
      o_wb_sel        = sel_a[grant];
      o_wb_dat        = dat_a[grant];
      o_wb_4_burst    = i_wb_4_burst[grant];
      o_wb_8_burst    = i_wb_8_burst[grant];
    end
  end

  assign o_wb_ack      = owner_oh & {NUM_M{i_wb_ack}};
  assign o_wb_err      = owner_oh & {NUM_M{i_wb_err | fire}};
  assign o_wb_rty      = owner_oh & {NUM_M{i_wb_rty}};
  assign o_grant       = grant;
  assign o_grant_valid = gv;
endmodule

// File: doc/wishbone_arbiter_n.md
Name: wishbone_arbiter_n

Overview:
- Parametrised N-master Wishbone arbiter. Successor to the fixed 2-input arbiter that is currently cascaded for icache and data/fetch arbitration.
- One instance replaces the cascaded tree: dcache plus any number of icaches onto the single external bus.
- Adds selectable fixed-priority or round-robin arbitration, grant held for the whole cycle (burst-safe), and an optional per-transfer stall watchdog that terminates hung slaves with err.

Parameters:
NUM_M, 4, number of masters (2..8)
ADDR_W, 24, wishbone address width
DATA_W, 16, wishbone data width
SEL_W, 2, byte-select width
RR_MODE, 1, 0 = fixed priority (lowest index wins, legacy behaviour); 1 = round-robin
TIMEOUT, 0, stall watchdog limit in cycles; 0 disables the watchdog

Ports:
i_clk  in  1  clock
i_rst  in  1  async active-high reset
i_wb_cyc  in  NUM_M  per-master cyc
i_wb_stb  in  NUM_M  per-master stb
i_wb_we  in  NUM_M  per-master we
i_wb_adr  in  NUM_M*ADDR_W  flattened addresses; master k at [k*ADDR_W +: ADDR_W]
i_wb_sel  in  NUM_M*SEL_W  flattened byte selects
i_wb_dat  in  NUM_M*DATA_W  flattened write data
i_wb_4_burst  in  NUM_M  per-master 4-beat burst hint
i_wb_8_burst  in  NUM_M  per-master 8-beat burst hint
o_wb_ack  out  NUM_M  per-master ack
o_wb_err  out  NUM_M  per-master err
o_wb_rty  out  NUM_M  per-master rty
o_wb_cyc  out  1  bus cyc
o_wb_stb  out  1  bus stb
o_wb_we  out  1  bus we
o_wb_adr  out  ADDR_W  bus address
o_wb_sel  out  SEL_W  bus byte select
o_wb_dat  out  DATA_W  bus write data
o_wb_4_burst  out  1  bus burst hint
o_wb_8_burst  out  1  bus burst hint
i_wb_ack  in  1  bus ack
i_wb_err  in  1  bus err
i_wb_rty  in  1  bus rty
o_grant  out  $clog2(NUM_M)  index of current owner, for debug/select
o_grant_valid  out  1  a master currently owns the bus

Behaviour:
- Read data is not routed by this block; the bus read data is broadcast to all masters externally.

Registered state:
- grant_valid, grant index, last-owner pointer, watchdog counter.

Reset:
- Asynchronous; takes effect immediately, including mid-transfer.
- grant_valid=0, grant=0, last-owner pointer = NUM_M-1, so round-robin starts at master 0. Counter = 0.
- Consequently all outputs are 0: o_wb_cyc, o_wb_stb and all ack/err/rty are forced low.

States:
- IDLE (grant_valid=0).
- OWNED (grant_valid=1).

IDLE:
- If any i_wb_cyc is high at a clock edge, grant the winner and go to OWNED.
- The bus sees o_wb_cyc one cycle after the request (1-cycle arbitration latency).

Winner selection:
- RR_MODE=0: lowest requesting index wins.
- RR_MODE=1: first requester scanning from (last_owner+1) mod NUM_M upward, with wrap-around.

OWNED:
- o_wb_cyc = i_wb_cyc[grant]. o_wb_stb, we, adr, sel, dat and burst hints are muxed combinationally from the owner.
- The grant is held while i_wb_cyc[grant]=1, regardless of other requests and across burst beats.
- At an edge where i_wb_cyc[grant]=0:
  - last_owner <= grant.
  - If other requesters are present, grant the next winner directly (no dead cycle beyond the owner's own cyc-low cycle).
  - Otherwise go to IDLE.
  - The releasing master is eligible again, but in RR_MODE=1 it has lowest priority.

Response routing:
- o_wb_ack/err/rty[grant] = i_wb_ack/err/rty & grant_valid.
- All other masters see 0.
- Bus responses arriving while in IDLE are dropped.

Watchdog (TIMEOUT>0):
- The counter increments each cycle o_wb_stb=1 and no ack/err/rty is received.
- It clears on any response, on grant change, or when stb is low.
- When the counter reaches TIMEOUT-1 while still stalled:
  - For that cycle, o_wb_err[grant]=1 and o_wb_stb is masked to 0.
  - The counter clears.
  - The master decides whether to drop cyc.
- A real bus response in the same cycle takes precedence: the real response is passed through and no err is injected.
- TIMEOUT=0: the counter is removed and no err is ever injected.

Widths:
- Grant index is $clog2(NUM_M) bits.
- Round-robin wrap is computed modulo NUM_M; non-power-of-two NUM_M must never select an index >= NUM_M.

Decomposition:
- Shared config package constants: default ADDR_W/DATA_W/SEL_W (matching the global WB widths) and the RR_MODE encodings ARB_FIXED=0, ARB_RR=1.
- One natural sub-module: wb_arb_pick. It is combinational: given a request vector, the last-owner pointer and the mode, it returns the winner index and an any-request flag. It is parametrised by NUM_M.
- The muxing and the state machine stay in wishbone_arbiter_n.

Test Plan:
1. NUM_M=4, RR_MODE=1, all cyc raised after reset at cycle 0; each master holds cyc for 3 cycles.
   - Expected: grant order 0,1,2,3,0; o_wb_cyc first high at cycle 1; no ack leaks to non-owners.
2. RR_MODE=0, masters 1 and 3 request continuously, each cycle 2 cycles long.
   - Expected: master 1 always wins and master 3 starves, matching legacy behaviour.
   - Repeat with RR_MODE=1: grants alternate 1,3,1,3.
3. Master 2 issues an 8-beat burst (i_wb_8_burst=1, cyc held 9 cycles) while master 0 requests.
   - Expected: grant stays 2 through all 8 acks; master 0 is granted on the edge after master 2 drops cyc.
4. TIMEOUT=16, master 1 strobes and the slave never acks.
   - Expected: o_wb_err[1] pulses exactly one cycle, 16 cycles after stb rose; o_wb_stb is low that cycle.
   - Then ack the retried strobe after 3 cycles: no err is injected.
5. Assert i_rst mid-transfer while master 3 owns the bus with stb high.
   - Expected: o_wb_cyc, o_wb_stb and o_grant_valid drop in the same cycle, before any clock edge.
   - After release with all masters requesting, grant=0.
6. NUM_M=3, RR_MODE=1, last owner 2, requests {0,2}.
   - Expected: wrap selects 0; o_grant is never 3.
